// File: rtl/step_gate_tracker_pkg.sv
// Shared types and constants for the stepper output gate: FSM states,
// fault-bit positions and default driver timing in 50 MHz cycles.
package step_gate_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIR_WAIT = 2'd1,
    PULSE_HI = 2'd2,
    PULSE_LO = 2'd3
  } gate_state_t;

  localparam int FAULT_LIMIT = 0;
  localparam int FAULT_BUSY  = 1;
  localparam int FAULT_WRAP  = 2;
  localparam int FAULT_W     = 3;

  localparam int POS_W    = 32;
  localparam int PERIOD_W = 24;
  localparam int TIMER_W  = 16;

  localparam int                  DEF_DIR_SETUP_CYC = 250;
  localparam int                  DEF_MIN_PULSE_CYC = 100;
  localparam logic [PERIOD_W-1:0] DEF_STALL_CYC     = 24'd5000000;

  // The timer counts down to zero inclusive, so an N-cycle interval loads N-1.
  function automatic logic [TIMER_W-1:0] cycLoad(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/step_gate_tracker_if.sv
// Driver-side signal bundle: raw step/dir and limit controls from the motor
// controller, gated pins and position/velocity status back out.
interface step_gate_tracker_if;
  import step_gate_tracker_pkg::*;

  logic                       step_in;
  logic                       dir_in;
  logic                       home;
  logic                       limEna;
  logic signed [POS_W-1:0]    limLo;
  logic signed [POS_W-1:0]    limHi;
  logic                       clrFault;

  logic                       step_out;
  logic                       dir_out;
  logic signed [POS_W-1:0]    cur_position;
  logic        [PERIOD_W-1:0] stepPeriod;
  logic                       moving;
  logic                       atLimLo;
  logic                       atLimHi;
  logic        [FAULT_W-1:0]  faultBits;

  modport master (
    output step_in, dir_in, home, limEna, limLo, limHi, clrFault,
    input  step_out, dir_out, cur_position, stepPeriod, moving,
           atLimLo, atLimHi, faultBits
  );

  modport slave (
    input  step_in, dir_in, home, limEna, limLo, limHi, clrFault,
    output step_out, dir_out, cur_position, stepPeriod, moving,
           atLimLo, atLimHi, faultBits
  );

endinterface

// File: rtl/step_gate_tracker_pulse_timer.sv
// Loadable down-counter with a zero flag; times direction setup and the
// minimum high/low phases of each output step.
module pulse_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/step_gate_tracker.sv
// Stepper output gate: enforces dir setup and pulse widths, blocks steps past
// soft limits, and tracks shaft position and step period.
module step_gate_tracker
  import step_gate_tracker_pkg::*;
#(
  parameter int                  DIR_SETUP_CYC = DEF_DIR_SETUP_CYC,
  parameter int                  MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter logic [PERIOD_W-1:0] STALL_CYC     = DEF_STALL_CYC
) (
  input logic               CLK_50MHZ,
  input logic               RST_N,
  step_gate_tracker_if.slave bus
);

  localparam logic [TIMER_W-1:0]    DIR_LOAD   = cycLoad(DIR_SETUP_CYC);
  localparam logic [TIMER_W-1:0]    PULSE_LOAD = cycLoad(MIN_PULSE_CYC);
  localparam logic signed [POS_W-1:0] POS_MAX  = 32'sh7FFFFFFF;
  localparam logic signed [POS_W-1:0] POS_MIN  = 32'sh80000000;

  gate_state_t                state;
  logic                       stepPrev;
  logic                       stepRise;
  logic                       stepOut;
  logic                       dirOut;
  logic signed [POS_W-1:0]    curPos;
  logic        [PERIOD_W-1:0] periodCnt;
  logic        [PERIOD_W-1:0] stepPeriod;
  logic        [FAULT_W-1:0]  faultBits;

  logic                       timerZero;
  logic                       tmrLoad;
  logic        [TIMER_W-1:0]  tmrLoadVal;

  logic                       acceptRise;
  logic                       dirReq;
  logic                       issueReq;
  logic                       dropRise;
  logic                       blocked;
  logic                       wrap;
  logic signed [POS_W-1:0]    posStep;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acceptRise = stepRise & ((state == IDLE) | ((state == PULSE_LO) & timerZero));
    dirReq     = acceptRise & (bus.dir_in != dirOut);
    issueReq   = (acceptRise & (bus.dir_in == dirOut)) | ((state == DIR_WAIT) & timerZero);
    dropRise   = stepRise & ~acceptRise;
    blocked    = bus.limEna & (dirOut ? (curPos >= bus.limHi) : (curPos <= bus.limLo));
    wrap       = dirOut ? (curPos == POS_MAX) : (curPos == POS_MIN);
    posStep    = dirOut ? (curPos + 32'sd1) : (curPos - 32'sd1);

    tmrLoad    = 1'b0;
    tmrLoadVal = PULSE_LOAD;
    if (dirReq) begin
      tmrLoad    = 1'b1;
      tmrLoadVal = DIR_LOAD;
    end else if (issueReq & ~blocked) begin
      tmrLoad    = 1'b1;
    end else if ((state == PULSE_HI) & timerZero) begin
      tmrLoad    = 1'b1;
    end
  end

  pulse_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .CLK_50MHZ (CLK_50MHZ),
    .RST_N     (RST_N),
    .load      (tmrLoad),
    .loadVal   (tmrLoadVal),
    .zero      (timerZero)
  );

  // Later assignments in this block override earlier ones: issue beats the
  // PULSE_LO exit, a fault event beats clrFault, home beats the position step.
  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      stepPrev   <= 1'b0;
      stepRise   <= 1'b0;
      stepOut    <= 1'b0;
      dirOut     <= 1'b0;
      curPos     <= '0;
      periodCnt  <= '1;
      stepPeriod <= '1;
      faultBits  <= '0;
    end else begin
      stepPrev <= bus.step_in;
      stepRise <= bus.step_in & ~stepPrev;

      if (periodCnt != '1) begin
        periodCnt <= periodCnt + 1'b1;
      end

      if (bus.clrFault) begin
        faultBits <= '0;
      end
      if (dropRise) begin
        faultBits[FAULT_BUSY] <= 1'b1;
      end

      case (state)
        PULSE_HI: if (timerZero) begin
          stepOut <= 1'b0;
          state   <= PULSE_LO;
        end
        PULSE_LO: if (timerZero) begin
          state <= IDLE;
        end
        default: ;
      endcase

      if (dirReq) begin
        dirOut <= bus.dir_in;
        state  <= DIR_WAIT;
      end

      if (issueReq) begin
        if (blocked) begin
          faultBits[FAULT_LIMIT] <= 1'b1;
          state                  <= IDLE;
        end else begin
          stepOut    <= 1'b1;
          curPos     <= posStep;
          stepPeriod <= periodCnt;
          periodCnt  <= PERIOD_W'(1);
          state      <= PULSE_HI;
          if (wrap & ~bus.home) begin
            faultBits[FAULT_WRAP] <= 1'b1;
          end
        end
      end

      if (bus.home) begin
        curPos <= '0;
      end
    end
  end

  assign bus.step_out     = stepOut;
  assign bus.dir_out      = dirOut;
  assign bus.cur_position = curPos;
  assign bus.stepPeriod   = stepPeriod;
  assign bus.faultBits    = faultBits;
  assign bus.moving       = (state != IDLE) | (periodCnt < STALL_CYC);
  assign bus.atLimHi      = bus.limEna & (curPos >= bus.limHi);
  assign bus.atLimLo      = bus.limEna & (curPos <= bus.limLo);

endmodule

// File: tb/tb_step_gate_tracker.sv
// Directed bench for step_gate_tracker: timing, limits, busy drops, wrap,
// home priority and asynchronous reset in the middle of a pulse.
module tb_step_gate_tracker;
  import step_gate_tracker_pkg::*;

  logic CLK_50MHZ = 1'b0;
  logic RST_N     = 1'b0;

  int checks = 0;
  int errors = 0;

  int   cyc       = 0;
  int   rises     = 0;
  int   hiRun     = 0;
  int   lastHigh  = 0;
  int   minHigh   = 32'h7FFFFFFF;
  int   maxHigh   = 0;
  int   riseCyc   = 0;
  int   dirChgCyc = 0;
  logic outPrev   = 1'b0;
  logic dirPrev   = 1'b0;
  int   base;

  step_gate_tracker_if bus ();

  step_gate_tracker dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST_N     (RST_N),
    .bus       (bus)
  );

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  // Pin monitor: counts output pulses, their high widths and dir-to-step spacing.
  always @(negedge CLK_50MHZ) begin
    cyc++;
    if (bus.step_out) hiRun++;
    if (bus.step_out && !outPrev) begin
      rises++;
      riseCyc = cyc;
    end
    if (!bus.step_out && outPrev) begin
      lastHigh = hiRun;
      if (hiRun < minHigh) minHigh = hiRun;
      if (hiRun > maxHigh) maxHigh = hiRun;
      hiRun = 0;
    end
    if (bus.dir_out != dirPrev) dirChgCyc = cyc;
    outPrev = bus.step_out;
    dirPrev = bus.dir_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_50MHZ);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepOnce(input logic d, input int gap);
    bus.dir_in  = d;
    bus.step_in = 1'b1;
    tick(5);
    bus.step_in = 1'b0;
    tick(gap - 5);
  endtask

  task automatic clearFaults();
    bus.clrFault = 1'b1;
    tick(1);
    bus.clrFault = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.step_in  = 1'b0;
    bus.dir_in   = 1'b0;
    bus.home     = 1'b0;
    bus.limEna   = 1'b0;
    bus.limLo    = '0;
    bus.limHi    = '0;
    bus.clrFault = 1'b0;

    // Reset state
    tick(3);
    check("rst step_out",   32'(bus.step_out), 0);
    check("rst dir_out",    32'(bus.dir_out), 0);
    check("rst position",   bus.cur_position, 0);
    check("rst stepPeriod", 32'(bus.stepPeriod), 32'hFFFFFF);
    check("rst moving",     32'(bus.moving), 0);
    check("rst faultBits",  32'(bus.faultBits), 0);
    RST_N = 1'b1;
    tick(2);

    // Ten steps up at a 1000-cycle period; the first also pays dir setup
    stepOnce(1'b1, 1000);
    bus.step_in = 1'b1;
    tick(1);
    check("same-dir latency +1", 32'(bus.step_out), 0);
    tick(1);
    check("same-dir latency +2", 32'(bus.step_out), 1);
    tick(3);
    bus.step_in = 1'b0;
    tick(995);
    repeat (8) stepOnce(1'b1, 1000);
    check("run pulse count", rises, 10);
    check("run min high",    minHigh, 100);
    check("run max high",    maxHigh, 100);
    check("run position",    bus.cur_position, 10);
    check("run stepPeriod",  32'(bus.stepPeriod), 1000);
    check("run moving",      32'(bus.moving), 1);

    // Direction reversal: dir_out moves 2 cycles after step_in, step 250 later
    bus.dir_in  = 1'b0;
    bus.step_in = 1'b1;
    tick(1);
    check("rev dir_out +1", 32'(bus.dir_out), 1);
    tick(1);
    check("rev dir_out +2", 32'(bus.dir_out), 0);
    tick(3);
    bus.step_in = 1'b0;
    tick(400);
    check("rev setup cycles", riseCyc - dirChgCyc, 250);
    check("rev position",     bus.cur_position, 9);
    check("rev pulse count",  rises, 11);
    check("rev high width",   lastHigh, 100);
    tick(600);

    // Upper soft limit at 3: five requests, three issued
    bus.limLo  = -32'sd100;
    bus.limHi  = 32'sd3;
    bus.limEna = 1'b1;
    bus.home   = 1'b1;
    tick(1);
    bus.home   = 1'b0;
    tick(1);
    check("home position", bus.cur_position, 0);
    base = rises;
    repeat (5) stepOnce(1'b1, 1000);
    check("lim pulse count", rises - base, 3);
    check("lim position",    bus.cur_position, 3);
    check("lim atLimHi",     32'(bus.atLimHi), 1);
    check("lim atLimLo",     32'(bus.atLimLo), 0);
    check("lim faultBits",   32'(bus.faultBits), 1);
    clearFaults();
    check("lim clrFault",    32'(bus.faultBits), 0);
    bus.limEna = 1'b0;
    tick(2);

    // Second rise 50 cycles into a pulse is dropped
    base = rises;
    bus.dir_in  = 1'b1;
    bus.step_in = 1'b1;
    tick(5);
    bus.step_in = 1'b0;
    tick(45);
    bus.step_in = 1'b1;
    tick(5);
    bus.step_in = 1'b0;
    tick(400);
    check("busy pulse count", rises - base, 1);
    check("busy position",    bus.cur_position, 4);
    check("busy faultBits",   32'(bus.faultBits), 2);
    clearFaults();

    // Positive wrap from the maximum signed position
    force dut.curPos = 32'sh7FFFFFFF;
    tick(1);
    release dut.curPos;
    tick(1);
    check("wrap preload", bus.cur_position, 32'h7FFFFFFF);
    stepOnce(1'b1, 400);
    check("wrap position",  bus.cur_position, 32'h80000000);
    check("wrap faultBits", 32'(bus.faultBits), 4);
    clearFaults();

    // home on the issue edge wins over the +1, pulse still goes out
    base = rises;
    bus.step_in = 1'b1;
    tick(1);
    bus.home = 1'b1;
    tick(1);
    bus.home = 1'b0;
    check("home+step step_out", 32'(bus.step_out), 1);
    check("home+step position", bus.cur_position, 0);
    tick(3);
    bus.step_in = 1'b0;
    tick(300);
    check("home+step pulses",    rises - base, 1);
    check("home+step faultBits", 32'(bus.faultBits), 0);

    // Asynchronous reset while step_out is high
    bus.step_in = 1'b1;
    tick(2);
    check("pre-reset step_out", 32'(bus.step_out), 1);
    tick(10);
    #3;
    RST_N = 1'b0;
    #1;
    check("async rst step_out",   32'(bus.step_out), 0);
    check("async rst dir_out",    32'(bus.dir_out), 0);
    check("async rst position",   bus.cur_position, 0);
    check("async rst stepPeriod", 32'(bus.stepPeriod), 32'hFFFFFF);
    check("async rst moving",     32'(bus.moving), 0);
    bus.step_in = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(5);

    base = rises;
    stepOnce(1'b1, 1000);
    check("post-rst pulses",     rises - base, 1);
    check("post-rst position",   bus.cur_position, 1);
    check("post-rst high width", lastHigh, 100);
    check("post-rst setup",      riseCyc - dirChgCyc, 250);
    check("post-rst stepPeriod", 32'(bus.stepPeriod), 32'hFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_gate_tracker.md
# step_gate_tracker

Downstream stage of the motor controller: takes its raw `step`/`dir` outputs and drives the stepper driver pins. It enforces driver timing (direction setup, minimum pulse high/low) and blocks steps beyond software position limits. It also keeps the authoritative 32-bit signed shaft position and measures the step period for velocity readback. All logic runs in one clock domain; `step_in` and `dir_in` are already synchronous to `CLK_50MHZ`.

## Interface
Parameters:
- `DIR_SETUP_CYC`, 250 — cycles between a `dir_out` change and the following `step_out` rise (5 µs).
- `MIN_PULSE_CYC`, 100 — minimum `step_out` high time, and also minimum low time after the pulse (2 µs each).
- `STALL_CYC`, 24'd5000000 — period count above which the axis reads as not moving (100 ms).

Ports (clock and reset first):
- `CLK_50MHZ` in 1 — system clock.
- `RST_N` in 1 — reset, asynchronous, active-low.
- `step_in` in 1 — raw step from the motor controller; only rising edges matter.
- `dir_in` in 1 — raw direction; 1 = increment position.
- `home` in 1 — one-cycle pulse; zeroes the position.
- `limEna` in 1 — enables the soft limits.
- `limLo` in 32 — signed lower soft limit.
- `limHi` in 32 — signed upper soft limit.
- `clrFault` in 1 — clears `faultBits`.
- `step_out` out 1 — step pin to the driver.
- `dir_out` out 1 — direction pin to the driver.
- `cur_position` out 32 — signed position count.
- `stepPeriod` out 24 — cycles between the last two issued pulses; saturates.
- `moving` out 1 — axis is active.
- `atLimLo` out 1, `atLimHi` out 1 — position is at or beyond a limit.
- `faultBits` out 3 — sticky faults: [0] step blocked by limit, [1] step dropped while busy, [2] position wrap.

## Operation
- Reset values: `step_out`=0, `dir_out`=0, `cur_position`=0, `stepPeriod`=24'hFFFFFF, internal period counter saturated, `faultBits`=0, `moving`=0, FSM=IDLE, `step_in` edge register=0.
- Edge detect: `stepRise` = `step_in` & ~previous `step_in` (registered).
- Limit check, using `dir_out` and the current `cur_position` (signed compare):
  - blocked = `limEna` & ((`dir_out` & `cur_position`>=`limHi`) | (~`dir_out` & `cur_position`<=`limLo`)).
- Issue action: if blocked, set `faultBits[0]` and go to IDLE. Otherwise:
  - `step_out`<=1; counter<=`MIN_PULSE_CYC`-1; position ±1 per `dir_out`;
  - `stepPeriod`<=period counter; period counter<=1; go to PULSE_HI.
- FSM:
  - IDLE: on `stepRise`, if `dir_in`≠`dir_out` then `dir_out`<=`dir_in`, counter<=`DIR_SETUP_CYC`-1, go to DIR_WAIT. Otherwise perform the issue action in the same cycle.
  - DIR_WAIT: decrement the counter; at 0, perform the issue action.
  - PULSE_HI: decrement; at 0, `step_out`<=0, counter<=`MIN_PULSE_CYC`-1, go to PULSE_LO.
  - PULSE_LO: decrement; at 0, go to IDLE. A `stepRise` in the same cycle the counter is 0 is handled as in IDLE.
- Any other `stepRise` outside IDLE is dropped and sets `faultBits[1]`; `dir_out` does not change.
- Wrap: incrementing 32'h7FFFFFFF or decrementing 32'h80000000 wraps two's-complement and sets `faultBits[2]`.
- `home` sets `cur_position`<=0 and beats a simultaneous ±1 update; the pulse itself is still issued.
- `clrFault` clears all bits; a fault event in the same cycle wins for its own bit.
- Period counter increments each cycle, saturating at 24'hFFFFFF.
- `moving` = (FSM≠IDLE) | (period counter < `STALL_CYC`).
- `atLimHi` = `limEna` & `cur_position`>=`limHi`; `atLimLo` likewise. Both are combinational from registers.

## Timing
- `stepRise` is seen 1 cycle after `step_in` rises. Same direction: `step_out` rises 1 cycle after that, i.e. 2 cycles after `step_in`.
- Direction change: `dir_out` changes 2 cycles after `step_in`; `step_out` rises exactly `DIR_SETUP_CYC` cycles after `dir_out`.
- `step_out` high time is exactly `MIN_PULSE_CYC` cycles; the minimum gap before the next rise is `MIN_PULSE_CYC` cycles.
- `cur_position` and `stepPeriod` update on the same edge `step_out` rises.
- Async reset mid-pulse: `step_out` drops to 0 immediately; no position update is committed.

## Structure
- Shared package: FSM state enum, fault-bit index constants, default cycle constants.
- One sub-module is natural: `pulse_timer`, a loadable down-counter with a zero flag, shared by DIR_WAIT, PULSE_HI and PULSE_LO.

## Test plan
- Reset, then 10 `step_in` pulses with `dir_in`=1 at a 1000-cycle period → 10 `step_out` pulses, each high 100 cycles; `cur_position`=10; `stepPeriod`=1000.
- `dir_in` toggles to 0 with a step → `dir_out` falls, then `step_out` rises exactly 250 cycles later; `cur_position` 10→9.
- `limEna`=1, `limHi`=3, 5 steps up → 3 pulses out, `cur_position`=3, `atLimHi`=1, `faultBits[0]`=1; `clrFault` → 0.
- Two `step_in` rises 50 cycles apart → one output pulse, `faultBits[1]`=1.
- Preload to 32'h7FFFFFFF via `home` plus steps (or a force), one step up → 32'h80000000, `faultBits[2]`=1; `home` coincident with a step → `cur_position`=0.
- `RST_N` low during PULSE_HI → all outputs at reset values asynchronously; after release, the next step behaves as in the first scenario.
